// File: rtl/fetch_group_decoder.sv
// rtl/fetch_group_decoder.sv - fetch PC generation, group register and intra-group RAW dependency decode
// One group per cycle from icache into a valid/ready output register; redirect flushes the held group.
module fetch_group_decoder #(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_W        = 16,
  parameter int ROB_IDX_W   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_redirect_valid,
  input  logic [PC_W-1:0]                  i_redirect_pc,
  output logic [FETCH_WIDTH*PC_W-1:0]      o_icache_pc,
  input  logic [FETCH_WIDTH*16-1:0]        i_icache_instr,
  input  logic                             i_icache_valid,
  input  logic [ROB_IDX_W-1:0]             i_rob_tail_idx,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [FETCH_WIDTH*PC_W-1:0]      o_out_pc,
  output logic [FETCH_WIDTH*4-1:0]         o_out_opcode,
  output logic [FETCH_WIDTH*4-1:0]         o_out_rt,
  output logic [FETCH_WIDTH*4-1:0]         o_out_ra,
  output logic [FETCH_WIDTH*4-1:0]         o_out_rb,
  output logic [FETCH_WIDTH-1:0]           o_out_a_dep,
  output logic [FETCH_WIDTH*ROB_IDX_W-1:0] o_out_a_owner,
  output logic [FETCH_WIDTH-1:0]           o_out_b_dep,
  output logic [FETCH_WIDTH*ROB_IDX_W-1:0] o_out_b_owner
);

  logic [PC_W-1:0]             r_fetch_pc;
  logic                        r_d_valid;
  logic [FETCH_WIDTH*16-1:0]   r_d_instr;
  logic [FETCH_WIDTH*PC_W-1:0] r_d_pc;

  logic            w_accept;
  logic [PC_W-1:0] w_redirect_pc;

  assign w_accept      = i_icache_valid & (~r_d_valid | i_out_ready);
  assign w_redirect_pc = i_redirect_pc & ~PC_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_d_valid  <= 1'b0;
      r_d_instr  <= '0;
      r_d_pc     <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_d_valid  <= 1'b0;
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + PC_W'(2 * FETCH_WIDTH);
      r_d_valid  <= 1'b1;
      r_d_instr  <= i_icache_instr;
      r_d_pc     <= o_icache_pc;
    end else if (r_d_valid & i_out_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < FETCH_WIDTH; g++) begin : g_lane
      assign o_icache_pc[g*PC_W +: PC_W] = r_fetch_pc + PC_W'(2 * g);
      assign o_out_opcode[g*4 +: 4]      = r_d_instr[g*16+12 +: 4];
      assign o_out_rt[g*4 +: 4]          = r_d_instr[g*16+8 +: 4];
      assign o_out_ra[g*4 +: 4]          = r_d_instr[g*16+4 +: 4];
      assign o_out_rb[g*4 +: 4]          = r_d_instr[g*16 +: 4];
    end
  endgenerate

  assign o_out_valid = r_d_valid;
  assign o_out_pc    = r_d_pc;

  function automatic logic f_uses_ra(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  function automatic logic f_uses_rb(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd10, 4'd11};
  endfunction

  function automatic logic f_writes_rt(input logic [3:0] op);
    return op <= 4'd9;
  endfunction

  // Scanning older lanes in ascending order lets the youngest matching producer win.
  always_comb begin
    o_out_a_dep   = '0;
    o_out_b_dep   = '0;
    o_out_a_owner = '0;
    o_out_b_owner = '0;
    for (int i = 1; i < FETCH_WIDTH; i++) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (j < i && f_writes_rt(o_out_opcode[j*4 +: 4])) begin
          if (f_uses_ra(o_out_opcode[i*4 +: 4]) && o_out_ra[i*4 +: 4] != 4'd0 &&
              o_out_rt[j*4 +: 4] == o_out_ra[i*4 +: 4]) begin
            o_out_a_dep[i] = 1'b1;
            o_out_a_owner[i*ROB_IDX_W +: ROB_IDX_W] = i_rob_tail_idx + ROB_IDX_W'(j);
          end
          if (f_uses_rb(o_out_opcode[i*4 +: 4]) && o_out_rb[i*4 +: 4] != 4'd0 &&
              o_out_rt[j*4 +: 4] == o_out_rb[i*4 +: 4]) begin
            o_out_b_dep[i] = 1'b1;
            o_out_b_owner[i*ROB_IDX_W +: ROB_IDX_W] = i_rob_tail_idx + ROB_IDX_W'(j);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_group_decoder.sv
// tb/tb_fetch_group_decoder.sv - self-checking bench for fetch_group_decoder
// Dependency vectors from a table, plus directed stall/redirect/wrap/reset sequences.
module tb_fetch_group_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [63:0] icache_pc;
  logic [63:0] icache_instr;
  logic        icache_valid;
  logic [3:0]  rob_tail_idx;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [15:0] out_opcode, out_rt, out_ra, out_rb;
  logic [3:0]  out_a_dep, out_b_dep;
  logic [15:0] out_a_owner, out_b_owner;

  int n_checks = 0;
  int n_errors = 0;

  fetch_group_decoder dut (
    .i_clk(clk), .i_rst(rst),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_icache_pc(icache_pc), .i_icache_instr(icache_instr), .i_icache_valid(icache_valid),
    .i_rob_tail_idx(rob_tail_idx),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
    .o_out_opcode(out_opcode), .o_out_rt(out_rt), .o_out_ra(out_ra), .o_out_rb(out_rb),
    .o_out_a_dep(out_a_dep), .o_out_a_owner(out_a_owner),
    .o_out_b_dep(out_b_dep), .o_out_b_owner(out_b_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] instr;
    logic [3:0]  tail;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  a_dep;
    logic [15:0] a_owner;
    logic [3:0]  b_dep;
    logic [15:0] b_owner;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pcs(input logic [15:0] base);
    return {base + 16'd6, base + 16'd4, base + 16'd2, base};
  endfunction

  initial begin
    // lane 0 in the low 16 bits of instr and the low nibble of each field/owner
    vecs[0] = '{{16'h0000,16'h1541,16'h1412,16'h1123}, 4'd14, 16'h0412, 16'h0123, 4'b0110, 16'h0FE0, 4'b0100, 16'h0E00};
    vecs[1] = '{{16'h0000,16'h1541,16'h1412,16'h1123}, 4'd15, 16'h0412, 16'h0123, 4'b0110, 16'h00F0, 4'b0100, 16'h0F00};
    vecs[2] = '{{16'h0000,16'h1030,16'h1310,16'h1300}, 4'd3,  16'h0310, 16'h0000, 4'b0100, 16'h0400, 4'b0000, 16'h0000};
    vecs[3] = '{{16'h0000,16'h0000,16'h1030,16'hA300}, 4'd5,  16'h0030, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000};
    vecs[4] = '{{16'h0000,16'h0000,16'h1030,16'h2300}, 4'd5,  16'h0030, 16'h0000, 4'b0010, 16'h0050, 4'b0000, 16'h0000};
    vecs[5] = '{{16'h0000,16'h0000,16'h2013,16'h1300}, 4'd2,  16'h0010, 16'h0030, 4'b0000, 16'h0000, 4'b0000, 16'h0000};
    vecs[6] = '{{16'h0000,16'h0000,16'h0013,16'h1300}, 4'd2,  16'h0010, 16'h0030, 4'b0000, 16'h0000, 4'b0010, 16'h0020};
    vecs[7] = '{{16'h0000,16'h0000,16'h8033,16'h8300}, 4'd9,  16'h0030, 16'h0030, 4'b0010, 16'h0090, 4'b0000, 16'h0000};
    vecs[8] = '{{16'h0000,16'h0000,16'h1100,16'h1000}, 4'd7,  16'h0000, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; icache_instr = '0;
    icache_valid = 1'b0; rob_tail_idx = '0; out_ready = 1'b0;
    step(); step();
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_icache_pc", icache_pc, 64'h0006_0004_0002_0000);
    chk("reset_out_pc", out_pc, 64'd0);
    chk("reset_deps", {56'd0, out_a_dep, out_b_dep}, 64'd0);
    chk("reset_owners", {32'd0, out_a_owner, out_b_owner}, 64'd0);

    // back-to-back streaming
    rst = 1'b0; icache_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_pc", out_pc, pcs(16'(8 * k)));
    end
    chk("stream_next_fetch", icache_pc, pcs(16'd24));

    // dependency table; each vector is accepted and decoded the following cycle
    for (int v = 0; v < 9; v++) begin
      icache_instr = vecs[v].instr;
      step();
      rob_tail_idx = vecs[v].tail;
      #1;
      chk($sformatf("v%0d_valid", v), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_ra", v), {48'd0, out_ra}, {48'd0, vecs[v].ra});
      chk($sformatf("v%0d_rb", v), {48'd0, out_rb}, {48'd0, vecs[v].rb});
      chk($sformatf("v%0d_a_dep", v), {60'd0, out_a_dep}, {60'd0, vecs[v].a_dep});
      chk($sformatf("v%0d_a_owner", v), {48'd0, out_a_owner}, {48'd0, vecs[v].a_owner});
      chk($sformatf("v%0d_b_dep", v), {60'd0, out_b_dep}, {60'd0, vecs[v].b_dep});
      chk($sformatf("v%0d_b_owner", v), {48'd0, out_b_owner}, {48'd0, vecs[v].b_owner});
    end
    chk("table_opcode_last", {48'd0, out_opcode}, 64'h0011);
    chk("table_rt_last", {48'd0, out_rt}, 64'h0010);

    // stall: group at 96 held for three cycles while owners follow rob_tail_idx
    icache_instr = vecs[0].instr; rob_tail_idx = 4'd14;
    step();
    chk("stall_load_pc", out_pc, pcs(16'd96));
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_out_pc", out_pc, pcs(16'd96));
      chk("stall_icache_pc", icache_pc, pcs(16'd104));
      chk("stall_a_owner", {48'd0, out_a_owner}, 64'h0FE0);
    end
    rob_tail_idx = 4'd15;
    #1;
    chk("stall_owner_track", {48'd0, out_a_owner}, 64'h00F0);
    out_ready = 1'b1;
    step();
    chk("release_pc", out_pc, pcs(16'd104));
    chk("release_valid", {63'd0, out_valid}, 64'd1);

    // redirect while stalled flushes the held group and drops the icache response
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0101;
    step();
    chk("redir_valid", {63'd0, out_valid}, 64'd0);
    chk("redir_icache_pc", icache_pc, pcs(16'h0100));
    redirect_valid = 1'b0;
    step();
    chk("post_redir_valid", {63'd0, out_valid}, 64'd1);
    chk("post_redir_pc", out_pc, pcs(16'h0100));

    // fetch_pc wrap at the top of the address space
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
    step();
    chk("wrap_redir_valid", {63'd0, out_valid}, 64'd0);
    chk("wrap_icache_pc", icache_pc, 64'hFFFE_FFFC_FFFA_FFF8);
    redirect_valid = 1'b0;
    step();
    chk("wrap_out_pc", out_pc, 64'hFFFE_FFFC_FFFA_FFF8);
    chk("wrap_next_fetch", icache_pc, pcs(16'h0000));

    // transfer with nothing new accepted drains the register
    icache_valid = 1'b0;
    step();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_fetch_hold", icache_pc, pcs(16'h0000));

    // reset in the middle of a stall discards everything
    icache_valid = 1'b1; out_ready = 1'b0;
    step();
    chk("prerst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    step();
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_icache_pc", icache_pc, 64'h0006_0004_0002_0000);
    chk("midrst_out_pc", out_pc, 64'd0);
    chk("midrst_fields", {out_opcode, out_rt, out_ra, out_rb}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
